// File: rtl/wb_slave_decoder_n.sv
// Wishbone classic-cycle decoder: one host port fanned out to NSLV slaves by base/mask,
// with registered response path, decode-error response, per-transaction timeout and error status.
module wb_slave_decoder_n #(
  parameter int unsigned          NSLV     = 4,
  parameter logic [NSLV*32-1:0]   SLV_BASE = {32'h3800_0000, 32'h3000_0000, 32'h3000_0100, 32'h3000_0200},
  parameter logic [NSLV*32-1:0]   SLV_MASK = {32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00},
  parameter int unsigned          TO_W     = 8,
  parameter int unsigned          TIMEOUT  = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NSLV-1:0]      m_cyc_o,
  output logic [NSLV-1:0]      m_stb_o,
  output logic                 m_we_o,
  output logic [3:0]           m_sel_o,
  output logic [31:0]          m_adr_o,
  output logic [31:0]          m_dat_o,
  input  logic [NSLV-1:0]      m_ack_i,
  input  logic [NSLV*32-1:0]   m_dat_i,
  output logic [15:0]          err_count_o,
  output logic [31:0]          last_err_adr_o
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;
  localparam int unsigned IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RESP_ACK = 2'd2,
    RESP_ERR = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic [CW-1:0]      err_cnt_q, err_cnt_d;
  logic [DW-1:0]      last_adr_q, last_adr_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               to_hit;
  logic [CW-1:0]      err_cnt_inc;
  logic [DW-1:0]      slv_dat [NSLV];

  // Per-slave view of the packed read-data bus
  for (genvar g = 0; g < NSLV; g++) begin : g_unpack
    assign slv_dat[g] = m_dat_i[DW*g +: DW];
  end

  // Address decode; scanning downwards leaves the lowest matching index
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((wbs_adr_i & SLV_MASK[DW*i +: DW]) == (SLV_BASE[DW*i +: DW] & SLV_MASK[DW*i +: DW])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign to_hit      = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));
  assign err_cnt_inc = (err_cnt_q == {CW{1'b1}}) ? err_cnt_q : err_cnt_q + CW'(1);

  // State register and registered response/status
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      err_cnt_q  <= '0;
      last_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      err_cnt_q  <= err_cnt_d;
      last_adr_q <= last_adr_d;
    end
  end

  // Next-state and response logic; ack beats timeout, timeout beats host abort
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = '0;
    err_cnt_d  = err_cnt_q;
    last_adr_d = last_adr_q;

    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (hit) begin
            idx_d   = hit_idx;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            err_d      = 1'b1;
            last_adr_d = wbs_adr_i;
            err_cnt_d  = err_cnt_inc;
            state_d    = RESP_ERR;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q + TO_W'(1);
        if (m_ack_i[idx_q]) begin
          ack_d   = 1'b1;
          dat_d   = wbs_we_i ? '0 : slv_dat[idx_q];
          state_d = RESP_ACK;
        end else if (to_hit) begin
          err_d      = 1'b1;
          last_adr_d = wbs_adr_i;
          err_cnt_d  = err_cnt_inc;
          state_d    = RESP_ERR;
        end else if (!wbs_cyc_i) begin
          state_d = IDLE;
        end
      end

      RESP_ACK: state_d = IDLE;
      RESP_ERR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Slave strobes follow the host only while a slave owns the bus, so reset drops them at once
  always_comb begin
    m_cyc_o = '0;
    m_stb_o = '0;
    if (state_q == BUSY) begin
      m_cyc_o[idx_q] = wbs_cyc_i;
      m_stb_o[idx_q] = wbs_stb_i;
    end
  end

  assign m_we_o  = wbs_we_i;
  assign m_sel_o = wbs_sel_i;
  assign m_adr_o = wbs_adr_i;
  assign m_dat_o = wbs_dat_i;

  assign wbs_ack_o      = ack_q;
  assign wbs_err_o      = err_q;
  assign wbs_dat_o      = dat_q;
  assign err_count_o    = err_cnt_q;
  assign last_err_adr_o = last_adr_q;

endmodule

// File: tb/tb_wb_slave_decoder_n.sv
// Directed bench for wb_slave_decoder_n; host responses are predicted into a scoreboard
// queue when a request is issued and popped when the decoder answers.
module tb_wb_slave_decoder_n;

  localparam int unsigned NSLV = 4;

  logic                 clk;
  logic                 rst;
  logic                 cyc, stb, we;
  logic [3:0]           sel;
  logic [31:0]          adr, wdat;
  logic                 ack_o, err_o;
  logic [31:0]          rdat_o;
  logic [NSLV-1:0]      m_cyc, m_stb;
  logic                 m_we;
  logic [3:0]           m_sel;
  logic [31:0]          m_adr, m_dat;
  logic [NSLV-1:0]      m_ack;
  logic [NSLV*32-1:0]   m_rdat;
  logic [15:0]          err_cnt;
  logic [31:0]          last_adr;

  typedef struct packed {
    logic        is_err;
    logic [31:0] dat;
  } resp_t;

  resp_t sb[$];
  int    tests = 0;
  int    fails = 0;

  // Slave 0 at 0x38xx_xxxx, slaves 1..3 at 0x3000_0000/0100/0200
  wb_slave_decoder_n #(
    .NSLV    (NSLV),
    .SLV_BASE({32'h3000_0200, 32'h3000_0100, 32'h3000_0000, 32'h3800_0000}),
    .SLV_MASK({32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFF00_0000}),
    .TO_W    (8),
    .TIMEOUT (4)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_cyc_i     (cyc),
    .wbs_stb_i     (stb),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (wdat),
    .wbs_ack_o     (ack_o),
    .wbs_err_o     (err_o),
    .wbs_dat_o     (rdat_o),
    .m_cyc_o       (m_cyc),
    .m_stb_o       (m_stb),
    .m_we_o        (m_we),
    .m_sel_o       (m_sel),
    .m_adr_o       (m_adr),
    .m_dat_o       (m_dat),
    .m_ack_i       (m_ack),
    .m_dat_i       (m_rdat),
    .err_count_o   (err_cnt),
    .last_err_adr_o(last_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic start(input logic [31:0] a, input logic w, input logic [31:0] d);
    step();
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    sel  = 4'hF;
    adr  = a;
    wdat = d;
  endtask

  task automatic host_drop();
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  // A response must be present now; compare it with the oldest prediction
  task automatic check_resp(input string tag);
    resp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb observed=response expected=none_pending", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_ack"}, 32'(ack_o), 32'(!e.is_err));
      chk({tag, "_err"}, 32'(err_o), 32'(e.is_err));
      chk({tag, "_dat"}, rdat_o, e.dat);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ackerr"}, {30'd0, ack_o, err_o}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    cyc    = 1'b0;
    stb    = 1'b0;
    we     = 1'b0;
    sel    = 4'h0;
    adr    = '0;
    wdat   = '0;
    m_ack  = '0;
    m_rdat = '0;

    // Reset state
    sample();
    chk("rst_ack",  32'(ack_o), 32'd0);
    chk("rst_err",  32'(err_o), 32'd0);
    chk("rst_dat",  rdat_o, 32'd0);
    chk("rst_mcyc", 32'(m_cyc), 32'd0);
    chk("rst_cnt",  32'(err_cnt), 32'd0);
    chk("rst_last", last_adr, 32'd0);
    rst = 1'b0;

    // Read slave 2, slave acks one cycle after its strobe
    start(32'h3000_0104, 1'b0, 32'h0);
    m_rdat[64 +: 32] = 32'hCAFE_F00D;
    sb.push_back('{is_err: 1'b0, dat: 32'hCAFE_F00D});
    sample();
    chk("rd_t0_stb", 32'(m_stb), 32'd0);
    step();
    sample();
    chk("rd_t1_stb", 32'(m_stb), 32'b0100);
    chk("rd_t1_cyc", 32'(m_cyc), 32'b0100);
    check_quiet("rd_t1");
    step();
    m_ack = 4'b0100;
    sample();
    check_quiet("rd_t2");
    step();
    m_ack = '0;
    host_drop();
    sample();
    check_resp("rd_t3");
    chk("rd_t3_stb", 32'(m_stb), 32'd0);
    step();
    sample();
    check_quiet("rd_t4");

    // Write slave 0, slave acks in its first strobe cycle
    start(32'h3800_0010, 1'b1, 32'h1234_5678);
    m_rdat[0 +: 32] = 32'hDEAD_BEEF;
    sb.push_back('{is_err: 1'b0, dat: 32'h0});
    step();
    m_ack = 4'b0001;
    sample();
    chk("wr_t1_cyc", 32'(m_cyc), 32'b0001);
    chk("wr_t1_dat", m_dat, 32'h1234_5678);
    chk("wr_t1_we",  32'(m_we), 32'd1);
    chk("wr_t1_adr", m_adr, 32'h3800_0010);
    check_quiet("wr_t1");
    step();
    m_ack = '0;
    host_drop();
    sample();
    check_resp("wr_t2");

    // Unmapped address: decode error at T1
    start(32'h2000_0000, 1'b0, 32'h0);
    sb.push_back('{is_err: 1'b1, dat: 32'h0});
    sample();
    chk("de_t0_cyc", 32'(m_cyc), 32'd0);
    step();
    host_drop();
    sample();
    check_resp("de_t1");
    chk("de_t1_cyc",  32'(m_cyc), 32'd0);
    chk("de_t1_cnt",  32'(err_cnt), 32'd1);
    chk("de_t1_last", last_adr, 32'h2000_0000);
    step();
    sample();
    check_quiet("de_t2");

    // Slave 1 never acks: strobe high for 4 cycles, then error
    start(32'h3000_0010, 1'b0, 32'h0);
    sb.push_back('{is_err: 1'b1, dat: 32'h0});
    for (int c = 1; c <= 4; c++) begin
      step();
      sample();
      chk($sformatf("to_t%0d_stb", c), 32'(m_stb), 32'b0010);
      check_quiet($sformatf("to_t%0d", c));
    end
    step();
    host_drop();
    sample();
    chk("to_t5_stb", 32'(m_stb), 32'd0);
    check_resp("to_t5");
    chk("to_t5_cnt",  32'(err_cnt), 32'd2);
    chk("to_t5_last", last_adr, 32'h3000_0010);

    // Ack from slave 3 while slave 2 is selected is ignored
    start(32'h3000_0108, 1'b0, 32'h0);
    m_rdat[64 +: 32] = 32'h5555_AAAA;
    m_rdat[96 +: 32] = 32'h3333_3333;
    sb.push_back('{is_err: 1'b0, dat: 32'h5555_AAAA});
    step();
    m_ack = 4'b1000;
    sample();
    chk("xa_t1_stb", 32'(m_stb), 32'b0100);
    step();
    m_ack = 4'b0100;
    sample();
    check_quiet("xa_t2");
    chk("xa_t2_stb", 32'(m_stb), 32'b0100);
    step();
    m_ack = '0;
    host_drop();
    sample();
    check_resp("xa_t3");

    // Ack lands on the timeout cycle: ack wins
    start(32'h3000_0020, 1'b0, 32'h0);
    m_rdat[32 +: 32] = 32'h0BAD_CAFE;
    sb.push_back('{is_err: 1'b0, dat: 32'h0BAD_CAFE});
    step();
    step();
    step();
    step();
    m_ack = 4'b0010;
    sample();
    chk("pr_t4_stb", 32'(m_stb), 32'b0010);
    step();
    m_ack = '0;
    host_drop();
    sample();
    check_resp("pr_t5");
    chk("pr_t5_cnt", 32'(err_cnt), 32'd2);

    // Host abort mid-BUSY: no response, error count unchanged
    start(32'h3000_0104, 1'b0, 32'h0);
    step();
    sample();
    chk("ab_t1_stb", 32'(m_stb), 32'b0100);
    step();
    host_drop();
    sample();
    chk("ab_t2_cyc", 32'(m_cyc), 32'd0);
    for (int c = 3; c <= 7; c++) begin
      step();
      sample();
      check_quiet($sformatf("ab_t%0d", c));
    end
    chk("ab_cnt", 32'(err_cnt), 32'd2);

    // Reset mid-BUSY acts without a clock edge
    start(32'h3000_0100, 1'b0, 32'h0);
    step();
    sample();
    chk("rb_t1_stb", 32'(m_stb), 32'b0100);
    #1;
    rst = 1'b1;
    #1;
    chk("rb_stb",  32'(m_stb), 32'd0);
    chk("rb_cyc",  32'(m_cyc), 32'd0);
    chk("rb_cnt",  32'(err_cnt), 32'd0);
    chk("rb_last", last_adr, 32'd0);
    chk("rb_resp", {30'd0, ack_o, err_o}, 32'd0);
    host_drop();
    sample();
    rst = 1'b0;

    // Decoder is back in IDLE and counts from zero
    start(32'h0000_1000, 1'b1, 32'h0);
    sb.push_back('{is_err: 1'b1, dat: 32'h0});
    step();
    host_drop();
    sample();
    check_resp("pr2_t1");
    chk("pr2_cnt",  32'(err_cnt), 32'd1);
    chk("pr2_last", last_adr, 32'h0000_1000);

    step();
    sample();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_slave_decoder_n.md
Name: wb_slave_decoder_n

Overview:
- Parametrised Wishbone classic-cycle decoder. Routes one host (management SoC) port to NSLV slave ports, e.g. AXI bridge, exmem, FIR control.
- Successor to the fixed two-way split. Adds base/mask decode per slave, a registered response path, a decode-error response, a per-transaction timeout and error status.
- Sits in user_project_wrapper between the host WB port and the user slaves.

Parameters:
- NSLV, 4: number of slave ports, 1..8.
- SLV_BASE, {32'h3800_0000, 32'h3000_0000, 32'h3000_0100, 32'h3000_0200}: packed NSLV×32 base addresses; slave i occupies bits [32i+31:32i].
- SLV_MASK, {32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00}: packed NSLV×32 compare masks.
- TO_W, 8: timeout counter width.
- TIMEOUT, 255: cycles in BUSY before error. 0 disables the timeout.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host cycle, strobe, write enable
- wbs_sel_i  in  4  host byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  host address, host write data
- wbs_ack_o  out  1  host acknowledge, registered
- wbs_err_o  out  1  host error, registered
- wbs_dat_o  out  32  host read data, registered
- m_cyc_o, m_stb_o  out  NSLV each  per-slave cycle and strobe, one-hot
- m_we_o  out  1  broadcast write enable
- m_sel_o  out  4  broadcast byte selects
- m_adr_o, m_dat_o  out  32 each  broadcast address and write data
- m_ack_i  in  NSLV  per-slave acknowledge
- m_dat_i  in  NSLV×32  packed per-slave read data
- err_count_o  out  16  saturating count of decode errors plus timeouts
- last_err_adr_o  out  32  address of the most recent error

Behaviour:
- Reset values: all outputs 0. State IDLE. Timeout counter 0. Reset is asynchronous and acts immediately; a transaction in flight is abandoned and m_cyc_o/m_stb_o drop at once.
- Decode: slave i matches when (wbs_adr_i & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]). The lowest matching index wins.
- m_we_o, m_sel_o, m_adr_o and m_dat_o pass straight through from the host.
- State IDLE:
  - On wbs_cyc_i & wbs_stb_i with a match: latch the slave index, clear the counter, go to BUSY.
  - With no match: go to RESP_ERR, capture the address, increment err_count_o.
- State BUSY:
  - m_cyc_o[idx] = wbs_cyc_i and m_stb_o[idx] = wbs_stb_i. All other bits are 0.
  - Counter increments each cycle.
  - If m_ack_i[idx]: register m_dat_i[idx] into wbs_dat_o and go to RESP_ACK.
  - Acks from non-selected slaves are ignored.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: drop the slave strobes, capture the address, increment the error count, go to RESP_ERR.
  - Else if wbs_cyc_i drops (host abort): go to IDLE with no response.
- State RESP_ACK: wbs_ack_o = 1 for exactly one cycle. wbs_dat_o holds the read data; it is 0 on writes. Slave strobes are low. Next state IDLE.
- State RESP_ERR: wbs_err_o = 1 for one cycle. wbs_dat_o = 0. Next state IDLE.
- Latency:
  - Host stb at cycle T0 gives slave stb at T1.
  - Slave ack at cycle Tk gives host ack at Tk+1.
  - Minimum transaction is 3 cycles.
  - Decode error: host err at T1.
- Ack precedence: if ack and timeout land on the same cycle, ack wins.
- Host ordering: the host must not re-assert stb in the RESP cycle. IDLE samples a new request only on the cycle after RESP.
- err_count_o saturates at 16'hFFFF.
- Never assert ack and err together. Never assert more than one m_cyc_o bit.

Test Plan:
- Read at 32'h3000_0104, slave 2 acks one cycle after its stb with 32'hCAFE_F00D -> m_stb_o = 4'b0100 at T1; wbs_ack_o = 1 and wbs_dat_o = 32'hCAFE_F00D at T3; ack lasts one cycle.
- Write at 32'h3800_0010, data 32'h1234_5678 -> only m_cyc_o[0] set; m_dat_o = 32'h1234_5678; host ack one cycle after m_ack_i[0].
- Access at unmapped 32'h2000_0000 -> wbs_err_o pulses at T1; no m_cyc_o activity; err_count_o = 1; last_err_adr_o = 32'h2000_0000.
- TIMEOUT=4 with slave 1 never acking -> m_stb_o[1] high for 4 cycles then low; wbs_err_o pulses once; err_count_o increments.
- Slave 3 acks while slave 2 is selected, then slave 2 acks -> the first ack is ignored; host ack follows slave 2 with slave 2's data.
- Assert wb_rst_i mid-BUSY, and separately drop wbs_cyc_i mid-BUSY -> all outputs 0 immediately on reset; on abort, return to IDLE with no ack or err and err_count_o unchanged.
